dram_burst_ctrl: RTL
====================

// Module: dram_burst_ctrl
// PURPOSE
//   68040-bus DRAM sequencer: single and 4-beat line-burst read/write cycles, page-mode columns, CBR refresh.
//   Generalises the byte-lane/RAS decoder to NBANKS banks with parametrised geometry and timing.
//   Registers the cycle, drives row/column multiplexed MA, per-bank RAS, CAS byte lanes, and terminates with TA.
//   Sits between the CPU bus/address decoder (SEL) and the DRAM array. All strobes active-high here.
// PARAMETERS
//   NBANKS      2    number of RAS banks (power of 2, 1..8); BANK_W = $clog2(NBANKS), 0 when NBANKS=1
//   ROW_W       10   row address bits; must be >= COL_W
//   COL_W       10   column address bits (longword granularity)
//   T_RCD       2    cycles RAS-to-CAS (ROW state length)
//   T_CAS       2    cycles CAS held per beat
//   T_RP        2    cycles RAS precharge after any access or refresh
//   T_RAS       3    cycles RAS held during refresh
//   REF_INTERVAL 390 cycles between refresh requests (15.6 us @ 25 MHz)
// PORTS
//   CLK      in   1       bus clock; all state changes on rising edge
//   RESET    in   1       asynchronous, active-high reset
//   TS       in   1       transfer start, one-cycle pulse
//   SEL      in   1       DRAM region select from address decoder; qualifies TS
//   RW       in   1       1 = read, 0 = write
//   SIZ      in   2       00 long, 01 byte, 10 word, 11 line (4 longwords)
//   A        in   ROW_W+COL_W+BANK_W+2  byte address
//   MA       out  ROW_W   multiplexed DRAM address (column zero-extended)
//   RAS      out  NBANKS  row strobe per bank
//   CAS      out  4       byte-lane column strobes; CAS[3] = D31:24
//   WE       out  1       write enable (= ~RW latched), valid ROW..last beat
//   TA       out  1       transfer acknowledge, one cycle per beat
//   BUSY     out  1       high whenever state != IDLE or a request is pending
//   ERR      out  1       sticky: request arrived while busy; clears only on RESET
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, refresh counter = REF_INTERVAL-1, pending flags cleared; applies mid-cycle.
//   Address split: col = A[COL_W+1:2], row = A[ROW_W+COL_W+1:COL_W+2], bank = A[top BANK_W bits].
//   Request latch: TS&SEL sampled -> A/RW/SIZ registered, req_pend set. TS&SEL while BUSY -> dropped, ERR set.
//   Refresh counter: decrements every cycle; at 0 sets ref_pend and reloads. Expiry with ref_pend already set: no queueing.
//   States: IDLE, ROW, COL, CGAP, PRE, RCAS, RRAS.
//   IDLE: ref_pend -> RCAS (refresh wins ties; latched access waits); else req_pend -> ROW; else stay.
//   ROW (T_RCD cycles): MA=row, RAS[bank]=1, WE=~RW; req_pend cleared on entry.
//   COL (T_CAS cycles): MA=col, CAS=lane mask; TA=1 in last COL cycle only.
//   Lane mask: long/line 1111; word A1=0 1100, A1=1 0011; byte A[1:0]=00..11 -> 1000,0100,0010,0001.
//   After beat: line with beats left -> CGAP (1 cycle, CAS=0, RAS held) -> COL; else -> PRE.
//   Line burst: col[1:0] starts at A[3:2], increments modulo 4 (wraps within line), col upper bits fixed.
//   PRE (T_RP cycles): RAS=0, CAS=0, WE=0, MA held; then IDLE.
//   Refresh (CBR): RCAS 1 cycle CAS=1111 RAS=0; RRAS T_RAS cycles all RAS=1, CAS=1111; then PRE. ref_pend cleared on RCAS entry.
//   Latency (defaults, TS sampled at edge 0): RAS from cycle 1, CAS cycles 3-4, TA cycle 4; line TA at 4,7,10,13; RAS low 14-15; IDLE 16.
//   Exactly one RAS bit active during access; TA never asserted outside COL; WE never 1 during refresh.
// TESTING
//   Long read A=0x0000_0010, bank 0 -> RAS[0] cycles 1-4, MA=row then col 0x004, CAS=1111 cycles 3-4, TA cycle 4 only, WE=0.
//   Byte write A=...01 then word write A=...10 -> CAS=0100 then 0011; WE=1 cycles 1-4; one TA each.
//   Line read A[3:2]=2 -> MA[1:0] per beat 2,3,0,1; TA at cycles 4,7,10,13; CAS=0 in 5,8,11; RAS drops cycle 14.
//   Force refresh expiry same cycle as TS&SEL -> RCAS/RRAS/PRE first, then access uses latched A; no ERR.
//   Second TS&SEL during line burst -> ignored, burst completes 4 TA, ERR=1 until RESET.
//   RESET pulse mid-burst (after TA #2) -> RAS/CAS/TA/WE/BUSY=0 immediately; first refresh REF_INTERVAL cycles after release.

Source files
------------

// File: rtl/dram_burst_ctrl_if.sv
// dram_burst_ctrl_if: CPU-side request and DRAM-side strobe bundle for the burst controller
interface dram_burst_ctrl_if #(
  parameter int NBANKS = 2,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10
);
  localparam int BANK_W = $clog2(NBANKS);
  localparam int AW = ROW_W + COL_W + BANK_W + 2;
  logic              TS;
  logic              SEL;
  logic              RW;
  logic [1:0]        SIZ;
  logic [AW-1:0]     A;
  logic [ROW_W-1:0]  MA;
  logic [NBANKS-1:0] RAS;
  logic [3:0]        CAS;
  logic              WE;
  logic              TA;
  logic              BUSY;
  logic              ERR;
  modport master (output TS, SEL, RW, SIZ, A, input MA, RAS, CAS, WE, TA, BUSY, ERR);
  modport slave  (input TS, SEL, RW, SIZ, A, output MA, RAS, CAS, WE, TA, BUSY, ERR);
endinterface

// File: rtl/dram_burst_ctrl.sv
// dram_burst_ctrl: 68040-bus DRAM sequencer with single/line-burst access and CBR refresh
module dram_burst_ctrl #(
  parameter int NBANKS       = 2,
  parameter int ROW_W        = 10,
  parameter int COL_W        = 10,
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int T_RAS        = 3,
  parameter int REF_INTERVAL = 390
) (
  input  logic CLK,
  input  logic RESET,
  dram_burst_ctrl_if.slave bus
);
  localparam int BANK_W = $clog2(NBANKS);
  localparam int BW = (BANK_W > 0) ? BANK_W : 1;
  localparam int AW = ROW_W + COL_W + BANK_W + 2;
  localparam int RCW = $clog2(REF_INTERVAL + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ROW = 3'd1, S_COL = 3'd2, S_CGAP = 3'd3,
                         S_PRE = 3'd4, S_RCAS = 3'd5, S_RRAS = 3'd6;
  logic [2:0]       state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [1:0]       beat_q, beat_d;
  logic [1:0]       col_lo_q, col_lo_d;
  logic [AW-1:0]    a_q, a_d;
  logic             rw_q, rw_d;
  logic [1:0]       siz_q, siz_d;
  logic             req_pend_q, req_pend_d;
  logic             ref_pend_q, ref_pend_d;
  logic [RCW-1:0]   ref_cnt_q, ref_cnt_d;
  logic             err_q, err_d;
  logic [ROW_W-1:0] ma_hold_q, ma_hold_d;
  logic             busy, accept, done, line, acc;
  logic [BW-1:0]    bank;
  logic [NBANKS-1:0] ras_one;
  logic [COL_W-1:0] col_v;
  logic [3:0]       lane;
  // Request latch, refresh timer and sticky error tracking
  always_comb begin
    busy       = (state_q != S_IDLE) || req_pend_q;
    accept     = bus.TS && bus.SEL && !busy;
    a_d        = accept ? bus.A : a_q;
    rw_d       = accept ? bus.RW : rw_q;
    siz_d      = accept ? bus.SIZ : siz_q;
    req_pend_d = accept ? 1'b1 : (state_q == S_IDLE && !ref_pend_q) ? 1'b0 : req_pend_q;
    ref_pend_d = (ref_cnt_q == '0) ? 1'b1 : (state_q == S_IDLE) ? 1'b0 : ref_pend_q;
    ref_cnt_d  = (ref_cnt_q == '0) ? RCW'(REF_INTERVAL - 1) : ref_cnt_q - 1'b1;
    err_d      = err_q | (bus.TS && bus.SEL && busy);
  end
  // Sequencer: each timed state loads tmr on entry and leaves when it reaches zero
  always_comb begin
    done     = tmr_q == '0;
    line     = siz_q == 2'b11;
    state_d  = state_q;
    tmr_d    = done ? tmr_q : tmr_q - 1'b1;
    beat_d   = beat_q;
    col_lo_d = col_lo_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_RCAS;
          tmr_d   = '0;
        end else if (req_pend_q) begin
          state_d  = S_ROW;
          tmr_d    = 8'(T_RCD - 1);
          beat_d   = '0;
          col_lo_d = a_q[3:2];
        end
      end
      S_ROW: if (done) begin
        state_d = S_COL;
        tmr_d   = 8'(T_CAS - 1);
      end
      S_COL: if (done) begin
        if (line && beat_q != 2'd3) begin
          state_d  = S_CGAP;
          tmr_d    = '0;
          beat_d   = beat_q + 1'b1;
          col_lo_d = col_lo_q + 1'b1;
        end else begin
          state_d = S_PRE;
          tmr_d   = 8'(T_RP - 1);
        end
      end
      S_CGAP: begin
        state_d = S_COL;
        tmr_d   = 8'(T_CAS - 1);
      end
      S_PRE: if (done) state_d = S_IDLE;
      S_RCAS: begin
        state_d = S_RRAS;
        tmr_d   = 8'(T_RAS - 1);
      end
      S_RRAS: if (done) begin
        state_d = S_PRE;
        tmr_d   = 8'(T_RP - 1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Strobe and address decode from the current state; MA holds its last value outside access
  always_comb begin
    acc        = (state_q == S_ROW) || (state_q == S_COL) || (state_q == S_CGAP);
    bank       = (NBANKS > 1) ? a_q[AW-1 -: BW] : '0;
    ras_one    = '0;
    ras_one[bank] = 1'b1;
    col_v      = a_q[COL_W+1:2];
    col_v[1:0] = col_lo_q;
    lane       = (siz_q == 2'b01) ? 4'b1000 >> a_q[1:0] :
                 (siz_q == 2'b10) ? (a_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    bus.RAS    = acc ? ras_one : (state_q == S_RRAS) ? '1 : '0;
    bus.CAS    = (state_q == S_COL) ? lane :
                 (state_q == S_RCAS || state_q == S_RRAS) ? 4'b1111 : 4'b0000;
    bus.TA     = (state_q == S_COL) && done;
    bus.WE     = acc && !rw_q;
    bus.MA     = (state_q == S_ROW) ? a_q[ROW_W+COL_W+1 -: ROW_W] :
                 (state_q == S_COL || state_q == S_CGAP) ? ROW_W'(col_v) : ma_hold_q;
    ma_hold_d  = bus.MA;
    bus.BUSY   = busy;
    bus.ERR    = err_q;
  end
  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      beat_q     <= '0;
      col_lo_q   <= '0;
      a_q        <= '0;
      rw_q       <= 1'b1;
      siz_q      <= '0;
      req_pend_q <= 1'b0;
      ref_pend_q <= 1'b0;
      ref_cnt_q  <= RCW'(REF_INTERVAL - 1);
      err_q      <= 1'b0;
      ma_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      beat_q     <= beat_d;
      col_lo_q   <= col_lo_d;
      a_q        <= a_d;
      rw_q       <= rw_d;
      siz_q      <= siz_d;
      req_pend_q <= req_pend_d;
      ref_pend_q <= ref_pend_d;
      ref_cnt_q  <= ref_cnt_d;
      err_q      <= err_d;
      ma_hold_q  <= ma_hold_d;
    end
  end
endmodule
